// File: rtl/async_fifo_rd_packer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : async_fifo_rd_pkg                                      |
// | Shared types and width helpers for the async_fifo read-side      |
// | packet packer: FSM state encoding, counter widths, packet-count  |
// | width.                                                           |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package async_fifo_rd_pkg;

   // IDLE: pending slot empty; HOLD: pending slot holds a word.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } rd_state_t;

   localparam int PKT_CNT_W = 16;

   // Width of the beat counter; sized to hold BURST_LEN itself.
   function automatic int beat_w(input int burst_len);
      return $clog2(burst_len + 1);
   endfunction

   // Width of the idle timer; must be able to reach TIMEOUT.
   function automatic int tmo_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/async_fifo_rd_packer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : async_fifo_rd_packer_if                              |
// | Valid/ready packet stream leaving the read-side packer.          |
// |   m_valid - beat valid          m_ready - downstream accept      |
// |   m_data  - beat data (DSIZE)   m_last  - final beat of packet   |
// | Modports: master (packer side), slave (sink side).               |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
interface async_fifo_rd_packer_if #(
   parameter int DSIZE = 16
) ();

   logic             m_valid;
   logic             m_ready;
   logic [DSIZE-1:0] m_data;
   logic             m_last;

   modport master (
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );

endinterface
`default_nettype wire

// File: rtl/async_fifo_rd_packer_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : async_fifo_rd_timer                                     |
// | Saturating idle counter. Clears on i_clr, counts on i_en, and    |
// | stops at TIMEOUT, where o_expired stays high until cleared.      |
// | Ports: rclk, rrst_n (async active-low), i_clr, i_en, o_expired.  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module async_fifo_rd_timer #(
   parameter int TIMEOUT = 64,
   parameter int TMO_W   = 7
) (
   input  wire  rclk,
   input  wire  rrst_n,
   input  wire  i_clr,
   input  wire  i_en,
   output logic o_expired
);

   localparam logic [TMO_W-1:0] c_TMO = TMO_W'(TIMEOUT);

   logic [TMO_W-1:0] r_cnt;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != c_TMO)) begin
         r_cnt <= r_cnt + TMO_W'(1);
      end
   end

   assign o_expired = (r_cnt == c_TMO);

endmodule
`default_nettype wire

// File: rtl/async_fifo_rd_packer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : async_fifo_rd_packer                                    |
// | Pops words from a fall-through async_fifo read port and emits    |
// | them as a valid/ready stream grouped into BURST_LEN-beat packets.|
// | Partial packets close on idle timeout or on a flush pulse.       |
// | Ports: rclk, rrst_n (async active-low)                           |
// |        rinc/rdata/rempty - FIFO read port                        |
// |        m_axis            - output stream (master modport)        |
// |        flush             - close current packet (1-cycle pulse)  |
// |        busy              - a word is held inside the block       |
// |        pkt_cnt           - completed packets, wraps at 2^16      |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module async_fifo_rd_packer
   import async_fifo_rd_pkg::*;
#(
   parameter int DSIZE     = 16,
   parameter int BURST_LEN = 16,
   parameter int TIMEOUT   = 64
) (
   input  wire                   rclk,
   input  wire                   rrst_n,
   output logic                  rinc,
   input  wire  [DSIZE-1:0]      rdata,
   input  wire                   rempty,
   async_fifo_rd_packer_if.master m_axis,
   input  wire                   flush,
   output logic                  busy,
   output logic [PKT_CNT_W-1:0]  pkt_cnt
);

   localparam int                  c_BEAT_W   = beat_w(BURST_LEN);
   localparam int                  c_TMO_W    = tmo_w(TIMEOUT);
   localparam logic [c_BEAT_W-1:0] c_BEAT_MAX = c_BEAT_W'(BURST_LEN - 1);

   rd_state_t             r_state;
   rd_state_t             w_state_nxt;
   logic                  r_active;
   logic [DSIZE-1:0]      r_p_data;
   logic                  r_o_valid;
   logic [DSIZE-1:0]      r_o_data;
   logic                  r_o_last;
   logic [c_BEAT_W-1:0]   r_beat;
   logic [PKT_CNT_W-1:0]  r_pkt_cnt;

   logic w_p_valid;
   logic w_fire;
   logic w_o_free;
   logic w_close;
   logic w_move;
   logic w_pop;
   logic w_expired;
   logic w_tmr_en;
   logic w_tmr_clr;

   assign w_p_valid = (r_state == HOLD);
   assign w_fire    = r_o_valid & m_axis.m_ready;
   assign w_o_free  = ~r_o_valid | w_fire;

   // Conditions that force the pending word out as a packet's last beat.
   assign w_close   = (r_beat == c_BEAT_MAX) | w_expired | flush;

   // Without a closing condition, the pending word may only advance when
   // the next word is available: its arrival proves the pending one is
   // not last. Expressing that as ~rempty breaks the move/pop loop.
   assign w_move    = w_p_valid & w_o_free & (w_close | ~rempty);

   // r_active holds off popping until the first edge after reset release,
   // so no word is drained from the FIFO while the block is in reset.
   assign w_pop     = r_active & ~rempty & (~w_p_valid | w_move);
   assign rinc      = w_pop;

   // Timer only advances while the held word could leave if it closed.
   assign w_tmr_en  = w_p_valid & rempty & w_o_free & ~w_move;
   assign w_tmr_clr = w_pop | w_move;

   async_fifo_rd_timer #(
      .TIMEOUT (TIMEOUT),
      .TMO_W   (c_TMO_W)
   ) u_timer (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .i_clr     (w_tmr_clr),
      .i_en      (w_tmr_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pop)            w_state_nxt = HOLD;
         HOLD:    if (w_move && !w_pop) w_state_nxt = IDLE;
         default:                       w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_active  <= 1'b0;
         r_p_data  <= '0;
         r_o_valid <= 1'b0;
         r_o_data  <= '0;
         r_o_last  <= 1'b0;
         r_beat    <= '0;
         r_pkt_cnt <= '0;
      end else begin
         r_active <= 1'b1;

         if (w_pop) begin
            r_p_data <= rdata;
         end

         if (w_move) begin
            r_o_valid <= 1'b1;
            r_o_data  <= r_p_data;
            r_o_last  <= w_close;
            r_beat    <= w_close ? '0 : (r_beat + c_BEAT_W'(1));
         end else if (w_fire) begin
            r_o_valid <= 1'b0;
         end

         if (w_fire && r_o_last) begin
            r_pkt_cnt <= r_pkt_cnt + PKT_CNT_W'(1);
         end
      end
   end

   assign m_axis.m_valid = r_o_valid;
   assign m_axis.m_data  = r_o_data;
   assign m_axis.m_last  = r_o_last;
   assign busy           = w_p_valid | r_o_valid;
   assign pkt_cnt        = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_rd_packer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_async_fifo_rd_packer                                 |
// | Scoreboard bench for async_fifo_rd_packer with a behavioural     |
// | fall-through FIFO model on the read side.                        |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_async_fifo_rd_packer;

   localparam int DSIZE = 16;
   localparam int BL    = 4;
   localparam int TMO   = 8;

   typedef struct packed {
      logic [DSIZE-1:0] d;
      logic             last;
      logic             chk;
   } exp_t;

   logic             rclk = 1'b0;
   logic             rrst_n;
   logic             rinc;
   logic [DSIZE-1:0] rdata;
   logic             rempty;
   logic             flush;
   logic             busy;
   logic [15:0]      pkt_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int e_pkt    = 0;
   int mon_beats = 0;
   int mon_pkts  = 0;

   logic [DSIZE-1:0] fifo_q[$];
   exp_t             exp_q[$];

   logic             have_prev;
   logic [DSIZE-1:0] prev_data;
   logic             prev_last;
   logic             wr_done;

   async_fifo_rd_packer_if #(.DSIZE(DSIZE)) m_if ();

   async_fifo_rd_packer #(
      .DSIZE     (DSIZE),
      .BURST_LEN (BL),
      .TIMEOUT   (TMO)
   ) dut (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .rinc    (rinc),
      .rdata   (rdata),
      .rempty  (rempty),
      .m_axis  (m_if),
      .flush   (flush),
      .busy    (busy),
      .pkt_cnt (pkt_cnt)
   );

   always #5 rclk = ~rclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge rclk);
         #1;
      end
   endtask

   task automatic push_fifo(input logic [DSIZE-1:0] d);
      fifo_q.push_back(d);
   endtask

   task automatic expect_beat(input logic [DSIZE-1:0] d, input logic last, input logic chk);
      exp_t e;
      e.d = d; e.last = last; e.chk = chk;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int bound);
      int cyc = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0 || !rempty || busy) && cyc < bound) begin
         tick(1);
         cyc++;
      end
      check("drain_in_time", 32'(cyc < bound), 32'd1);
   endtask

   // Fall-through FIFO model: head word visible whenever not empty.
   initial begin
      rempty = 1'b1;
      rdata  = '0;
   end

   always @(posedge rclk) begin
      if (rinc && !rempty && fifo_q.size() > 0) begin
         void'(fifo_q.pop_front());
      end
      rempty <= (fifo_q.size() == 0);
      rdata  <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
   end

   // Monitor: scoreboard compare, stream stability, packet length rules.
   always @(negedge rclk) begin
      if (!rrst_n) begin
         have_prev = 1'b0;
         mon_beats = 0;
         mon_pkts  = 0;
      end else begin
         if (rinc) check("no_pop_when_empty", 32'(rempty), 32'd0);
         if (have_prev) begin
            check("hold_valid", 32'(m_if.m_valid), 32'd1);
            check("hold_data", 32'(m_if.m_data), 32'(prev_data));
            check("hold_last", 32'(m_if.m_last), 32'(prev_last));
         end
         have_prev = m_if.m_valid && !m_if.m_ready;
         prev_data = m_if.m_data;
         prev_last = m_if.m_last;
         if (m_if.m_valid && m_if.m_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got data %0h last %0b expected no beat",
                        m_if.m_data, m_if.m_last);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("beat_data", 32'(m_if.m_data), 32'(e.d));
               if (e.chk) check("beat_last", 32'(m_if.m_last), 32'(e.last));
            end
            mon_beats++;
            check("pkt_len_le_burst", 32'(mon_beats <= BL), 32'd1);
            if (mon_beats == BL) check("last_at_full_pkt", 32'(m_if.m_last), 32'd1);
            if (m_if.m_last) begin
               mon_beats = 0;
               mon_pkts++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rrst_n     = 1'b0;
      flush      = 1'b0;
      m_if.m_ready = 1'b1;
      wr_done    = 1'b0;
      have_prev  = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      tick(1);
      check("rst_m_valid", 32'(m_if.m_valid), 32'd0);
      check("rst_m_data",  32'(m_if.m_data),  32'd0);
      check("rst_m_last",  32'(m_if.m_last),  32'd0);
      check("rst_busy",    32'(busy),         32'd0);
      check("rst_pkt_cnt", 32'(pkt_cnt),      32'd0);
      check("rst_rinc",    32'(rinc),         32'd0);
      tick(2);
      rrst_n = 1'b1;
      tick(2);

      // 1: two full packets 0..7
      for (int i = 0; i < 8; i++) begin
         push_fifo(16'(i));
         expect_beat(16'(i), (i == 3 || i == 7), 1'b1);
      end
      e_pkt += 2;
      wait_drain(100);
      check("t1_pkt_cnt", 32'(pkt_cnt), 32'(e_pkt));

      // 2: trickle of three words, last one closed by timeout
      push_fifo(16'hA0); expect_beat(16'hA0, 1'b0, 1'b1);
      push_fifo(16'hA1); expect_beat(16'hA1, 1'b0, 1'b1);
      push_fifo(16'hA2); expect_beat(16'hA2, 1'b1, 1'b1);
      e_pkt += 1;
      tick(6);
      check("t2_busy_holding", 32'(busy), 32'd1);
      check("t2_a2_not_out", 32'(exp_q.size()), 32'd1);
      wait_drain(100);
      check("t2_pkt_cnt", 32'(pkt_cnt), 32'(e_pkt));
      check("t2_busy_idle", 32'(busy), 32'd0);

      // 3: back-pressure with six words
      m_if.m_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         push_fifo(16'(i));
         expect_beat(16'(i), (i == 3 || i == 5), 1'b1);
      end
      e_pkt += 2;
      tick(10);
      check("t3_valid", 32'(m_if.m_valid), 32'd1);
      check("t3_data", 32'(m_if.m_data), 32'd0);
      check("t3_rinc", 32'(rinc), 32'd0);
      check("t3_fifo_left", 32'(fifo_q.size()), 32'd4);
      tick(10);
      check("t3_data_still", 32'(m_if.m_data), 32'd0);
      m_if.m_ready = 1'b1;
      wait_drain(100);
      check("t3_pkt_cnt", 32'(pkt_cnt), 32'(e_pkt));

      // 4: flush closes a partial packet; flush while empty does nothing
      push_fifo(16'hB0); expect_beat(16'hB0, 1'b0, 1'b1);
      push_fifo(16'hB1); expect_beat(16'hB1, 1'b1, 1'b1);
      e_pkt += 1;
      tick(5);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      wait_drain(20);
      check("t4_pkt_cnt", 32'(pkt_cnt), 32'(e_pkt));
      check("t4_busy_before_flush", 32'(busy), 32'd0);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      tick(5);
      check("t4_empty_flush_pkt", 32'(pkt_cnt), 32'(e_pkt));
      check("t4_empty_flush_valid", 32'(m_if.m_valid), 32'd0);

      // 5: reset mid-packet
      push_fifo(16'hC0); expect_beat(16'hC0, 1'b0, 1'b1);
      push_fifo(16'hC1); expect_beat(16'hC1, 1'b0, 1'b1);
      push_fifo(16'hC2);
      tick(6);
      check("t5_two_emitted", 32'(exp_q.size()), 32'd0);
      check("t5_busy_before_rst", 32'(busy), 32'd1);
      rrst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(m_if.m_valid), 32'd0);
      check("t5_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      tick(2);
      rrst_n = 1'b1;
      e_pkt = 0;
      tick(1);
      for (int i = 0; i < 4; i++) begin
         push_fifo(16'hD0 + 16'(i));
         expect_beat(16'hD0 + 16'(i), (i == 3), 1'b1);
      end
      e_pkt += 1;
      wait_drain(100);
      check("t5_pkt_cnt", 32'(pkt_cnt), 32'(e_pkt));

      // 6: random traffic, order and packet-length rules only
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               logic [DSIZE-1:0] d;
               int gap;
               d = DSIZE'($urandom);
               push_fifo(d);
               expect_beat(d, 1'b0, 1'b0);
               gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 14))
                                                 : int'($urandom_range(0, 1));
               tick(1 + gap);
            end
            wr_done = 1'b1;
         end
         begin
            while (!wr_done) begin
               m_if.m_ready = ($urandom_range(0, 99) < 70);
               tick(1);
            end
         end
      join
      m_if.m_ready = 1'b1;
      wait_drain(3000);
      check("t6_pkt_cnt", 32'(pkt_cnt), 32'(mon_pkts));
      check("t6_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/async_fifo_rd_packer.md
Name: async_fifo_rd_packer

Overview:
- Read-side consumer of async_fifo, running in the read clock domain.
- Pops words from the FIFO read port and presents them as a valid/ready stream.
- Groups words into packets of BURST_LEN beats and marks the final beat with m_last.
- Closes partial packets on idle timeout or explicit flush, so a trickling writer never stalls a packet indefinitely.

Parameters:
- DSIZE, 16, data width; matches the async_fifo DSIZE.
- BURST_LEN, 16, beats per full packet; legal range 1..65535.
- TIMEOUT, 64, idle cycles (FIFO empty, word held) before a partial packet closes; legal range >=1.

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  asynchronous active-low reset.
- rinc  out  1  FIFO pop; connects to async_fifo rinc.
- rdata  in  DSIZE  FIFO head word. The FIFO is instantiated with FALLTHROUGH="TRUE", so rdata is valid whenever rempty=0.
- rempty  in  1  FIFO empty flag.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  DSIZE  stream beat data.
- m_last  out  1  final beat of a packet.
- flush  in  1  single-cycle request to close the current packet.
- busy  out  1  a word is held inside the block.
- pkt_cnt  out  16  count of completed packets; wraps at 2^16.

Behaviour:
- Reset (async assert, sync release via rclk): rinc=0, m_valid=0, m_data=0, m_last=0, busy=0, pkt_cnt=0; beat counter=0, idle timer=0, state=IDLE.
- Storage: pending slot P (data) and output slot O (data, last). O drives m_data/m_last; m_valid = O valid.
- Lookahead: a word leaves P for O only once its last flag is known.
- fire = m_valid & m_ready.
- o_free = !O.valid | fire.
- pop = rinc & !rempty.
- rinc = !rempty & (P empty | move); rinc is combinational from rempty and slot state.
- move (P->O) requires P valid & o_free & one of:
  - (a) beat == BURST_LEN-1 -> last=1.
  - (b) pop this cycle -> last=0.
  - (c) idle timer == TIMEOUT -> last=1.
  - (d) flush -> last=1.
- Precedence when several hold: a, d, c each force last=1; otherwise b gives last=0.
- Popped word is written into P in the same cycle, so P refills as it drains.
- Latency: FIFO word visible (rempty=0) -> m_valid no earlier than 2 rclk later (P stage, then O stage).
- Throughput: 1 beat/cycle when FIFO stays non-empty and m_ready=1.
- FSM:
  - IDLE (P empty): pop -> HOLD.
  - HOLD (P valid): move without pop -> IDLE; move with pop -> HOLD; no move -> HOLD.
- beat counter: +1 on every move; cleared to 0 on move with last=1; never exceeds BURST_LEN-1.
- Idle timer:
  - Counts in HOLD while rempty=1 and no move; saturates at TIMEOUT.
  - Clears on pop or move.
  - Does not count while O is blocked (m_ready=0); closure occurs on the first o_free cycle after saturation.
- pkt_cnt: +1 when fire & m_last.
- busy = P valid | O valid.
- AXI stability: while m_valid=1 & m_ready=0, m_data and m_last hold constant.
- BURST_LEN=1: every beat has last=1 via (a); no lookahead wait.
- flush with P empty: no effect; zero-length packets are never produced and pkt_cnt is unchanged.
- flush while O is blocked: ignored (single-cycle request, not latched).
- Simultaneous flush and pop: P moves with last=1; the popped word starts the next packet in P.
- Reset mid-packet: held words are discarded, beat=0, pkt_cnt=0. Words still in the FIFO form new packets after release.
- Overflow/underflow: pop is never issued with rempty=1; the FIFO is never over-read.

Decomposition:
- Package async_fifo_rd_pkg holds:
  - state typedef (IDLE, HOLD);
  - BEAT_W = $clog2(BURST_LEN+1) and TMO_W = $clog2(TIMEOUT+1) as width functions;
  - PKT_CNT_W = 16.
- One sub-module async_fifo_rd_timer: saturating idle counter with clear, enable and "expired" output.
- Everything else is flat.

Test Plan:
- Write 8 words 0..7, m_ready=1, BURST_LEN=4, TIMEOUT=8 -> 8 beats, data 0..7; m_last=1 only on 3 and 7; pkt_cnt=2.
- Write 0xA0,0xA1,0xA2 then stop -> A0, A1 emitted with last=0; A2 held (busy=1); A2 emitted with m_last=1 after 8 empty cycles; pkt_cnt=1; busy=0.
- 6 words, m_ready=0 for 20 cycles -> m_valid=1 with m_data=0 stable; rinc=0 once P and O are full (FIFO keeps 4). Release m_ready -> 6 beats in order, last on beat 4.
- 2 words then flush pulse -> second word m_last=1, pkt_cnt=1. Flush with busy=0 -> no beat, pkt_cnt unchanged.
- Emit 2 of 4 beats, pulse rrst_n low -> m_valid=0, pkt_cnt=0 immediately. Then 4 fresh words -> one packet, last on the 4th.
- 1000 random words, random m_ready and write gaps -> data matches golden order; every packet is <=BURST_LEN beats; full packets carry last exactly at beat BURST_LEN.
